// File: rtl/dpram_stream_reader_pkg.sv
// Shared types and constants for the dual-port RAM stream reader.
// Optional ring-buffer addressing is selected by DPRAM_STREAM_READER_WRAP_EN.
package dpram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH    = 4;
  localparam int ISSUE_LATENCY = 2;

endpackage

// File: rtl/dpram_stream_reader_stream_fifo4.sv
// Four-entry register FIFO holding {last, data} beats for the stream reader output.
module stream_fifo4
  import dpram_stream_reader_pkg::*;
#(
  parameter int DW = 9,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointer, storage and occupancy update; a push into a full FIFO only lands alongside a pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != {CW{1'b0}});
    do_push  = push && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers, cleared so the head reads as zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Streams a (start, length) window of a registered-output dual-port RAM as valid/ready beats.
// Define DPRAM_STREAM_READER_WRAP_EN to let reads wrap from DEPTH-1 back to 0.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [AW-1:0]    CmdStart,
  input  logic [LW-1:0]    CmdLength,
  output logic             CmdError,
  output logic [AW-1:0]    RdAddress,
  input  logic [WIDTH-1:0] RamQ,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic             OutLast,
  output logic             Busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [LW-1:0]            rem_q, rem_d;
  logic [ISSUE_LATENCY-1:0] vld_q, vld_d;
  logic [ISSUE_LATENCY-1:0] lst_q, lst_d;
  logic                     err_q, err_d;
  logic                     issue, issue_last, cmd_illegal, credit_ok;
  logic                     fifo_empty, fifo_pop;
  logic [CW-1:0]            fifo_count, inflight;
  logic [WIDTH:0]           fifo_head;

`ifdef DPRAM_STREAM_READER_WRAP_EN
  assign cmd_illegal = (CmdLength == {LW{1'b0}}) || (CmdLength > LW'(DEPTH));
`else
  localparam int EW = LW + 1;
  logic [EW-1:0] cmd_end;
  assign cmd_end     = EW'(CmdStart) + EW'(CmdLength);
  assign cmd_illegal = (CmdLength == {LW{1'b0}}) || (CmdLength > LW'(DEPTH)) ||
                       (cmd_end > EW'(DEPTH));
`endif

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
`ifdef DPRAM_STREAM_READER_WRAP_EN
    if (a >= AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return a + AW'(1);
    end
`else
    return a + AW'(1);
`endif
  endfunction

  // Reads already in the RAM/alignment pipe count against FIFO space; a same-cycle pop earns no credit
  always_comb begin
    inflight = {CW{1'b0}};
    for (int i = 0; i < ISSUE_LATENCY; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
    credit_ok = (fifo_count + inflight) < CW'(FIFO_DEPTH);
  end

  assign fifo_pop = OutReady && !fifo_empty;

  // Next-state, read issue and error pulse
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (CmdValid && cmd_illegal) begin
          err_d = 1'b1;
        end else if (CmdValid) begin
          issue      = 1'b1;
          issue_last = (CmdLength == LW'(1));
          addr_d     = CmdStart;
          rem_d      = CmdLength - LW'(1);
          state_d    = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rem_q == {LW{1'b0}}) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem_q == LW'(1));
          addr_d     = next_addr(addr_q);
          rem_d      = rem_q - LW'(1);
          state_d    = (rem_q == LW'(1)) ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (fifo_pop && fifo_head[WIDTH]) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    vld_d = {vld_q[ISSUE_LATENCY-2:0], issue};
    lst_d = {lst_q[ISSUE_LATENCY-2:0], issue_last};
  end

  // Control registers; reset flushes the read pipeline along with the FSM
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= {AW{1'b0}};
      rem_q   <= {LW{1'b0}};
      vld_q   <= {ISSUE_LATENCY{1'b0}};
      lst_q   <= {ISSUE_LATENCY{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      err_q   <= err_d;
    end
  end

  stream_fifo4 #(.DW(WIDTH + 1)) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (vld_q[ISSUE_LATENCY-1]),
    .push_data ({lst_q[ISSUE_LATENCY-1], RamQ}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign CmdReady  = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign CmdError  = err_q;
  assign RdAddress = addr_q;
  assign OutValid  = !fifo_empty;
  assign OutData   = fifo_head[WIDTH-1:0];
  assign OutLast   = fifo_head[WIDTH] && !fifo_empty;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed scoreboard bench for dpram_stream_reader with a registered-output RAM model.
module tb_dpram_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_start;
  logic [LW-1:0]    cmd_length;
  logic             cmd_error;
  logic [AW-1:0]    rd_address;
  logic [WIDTH-1:0] ram_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  int               compared   = 0;
  int               mismatched = 0;
  int               cyc        = 0;
  int               hs;
  logic [WIDTH:0]   exp_q[$];
  int               beat_log[$];
  bit               stall_seen = 1'b0;
  logic [WIDTH:0]   stall_beat;
  logic [WIDTH:0]   exp_beat;
  logic [AW-1:0]    prev_addr;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents are 0x10 + address; read data is registered like the real RAM
  always @(posedge clk) begin
    if (rd_address < AW'(DEPTH)) ram_q <= 8'h10 + {4'h0, rd_address};
    else ram_q <= 8'h00;
  end

  dpram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .CmdValid  (cmd_valid),
    .CmdReady  (cmd_ready),
    .CmdStart  (cmd_start),
    .CmdLength (cmd_length),
    .CmdError  (cmd_error),
    .RdAddress (rd_address),
    .RamQ      (ram_q),
    .OutValid  (out_valid),
    .OutReady  (out_ready),
    .OutData   (out_data),
    .OutLast   (out_last),
    .Busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Beat monitor: pops the scoreboard on each handshake and checks hold-stability while stalled
  always @(negedge clk) begin
    #3;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_last, out_data}), 32'(stall_beat));
      end
      stall_seen = 1'b0;
      if (out_valid && out_ready) begin
        beat_log.push_back(cyc);
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          chk("beat", 32'({out_last, out_data}), 32'(exp_beat));
        end
      end else if (out_valid) begin
        stall_seen = 1'b1;
        stall_beat = {out_last, out_data};
      end
    end
  end

  task automatic send(input logic [AW-1:0] s, input logic [LW-1:0] l, input bit legal);
    logic [WIDTH-1:0] d;
    int a;
    step();
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_start  = s;
    cmd_length = l;
    hs         = cyc;
    if (legal) begin
      for (int i = 0; i < int'(l); i++) begin
        a = (int'(s) + i) % DEPTH;
        d = 8'(32'h10 + a);
        exp_q.push_back({(i == int'(l) - 1), d});
      end
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input bit toggle);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < bound) begin
      step();
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    chk("done_in_time", 32'(n < bound), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_start  = '0;
    cmd_length = '0;
    out_ready  = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_error", 32'(cmd_error), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_rd_address", 32'(rd_address), 32'd0);
    rst = 1'b0;

    // Start=2, Len=3 with consumer always ready
    out_ready = 1'b1;
    beat_log.delete();
    send(4'd2, 4'd3, 1'b1);
    chk("t1_rd_address_c1", 32'(rd_address), 32'd2);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_cmd_ready_c1", 32'(cmd_ready), 32'd0);
    step();
    chk("t1_out_valid_c2", 32'(out_valid), 32'd0);
    step();
    chk("t1_out_valid_c3", 32'(out_valid), 32'd1);
    chk("t1_out_data_c3", 32'(out_data), 32'h12);
    step();
    step();
    chk("t1_out_last_c5", 32'(out_last), 32'd1);
    chk("t1_out_data_c5", 32'(out_data), 32'h14);
    step();
    chk("t1_cmd_ready_c6", 32'(cmd_ready), 32'd1);
    chk("t1_busy_c6", 32'(busy), 32'd0);
    chk("t1_beat_count", 32'(beat_log.size()), 32'd3);
    for (int i = 0; i < beat_log.size() && i < 3; i++)
      chk("t1_beat_cycle", 32'(beat_log[i] - hs), 32'(3 + i));

    // Start=0, Len=8 with backpressure, then toggled ready
    out_ready = 1'b0;
    beat_log.delete();
    send(4'd0, 4'd8, 1'b1);
    repeat (9) step();
    chk("t2_rd_address_stalled", 32'(rd_address), 32'd3);
    chk("t2_out_valid_stalled", 32'(out_valid), 32'd1);
    chk("t2_out_data_stalled", 32'(out_data), 32'h10);
    chk("t2_busy_stalled", 32'(busy), 32'd1);
    wait_idle(200, 1'b1);
    chk("t2_beat_count", 32'(beat_log.size()), 32'd8);

    // Start=8, Len=4: ring read or range error depending on build
    out_ready = 1'b1;
`ifdef DPRAM_STREAM_READER_WRAP_EN
    beat_log.delete();
    send(4'd8, 4'd4, 1'b1);
    chk("t3_cmd_error", 32'(cmd_error), 32'd0);
    wait_idle(100, 1'b0);
    chk("t3_beat_count", 32'(beat_log.size()), 32'd4);
`else
    send(4'd8, 4'd4, 1'b0);
    chk("t3_cmd_error_c1", 32'(cmd_error), 32'd1);
    chk("t3_cmd_ready_c1", 32'(cmd_ready), 32'd1);
    chk("t3_busy_c1", 32'(busy), 32'd0);
    step();
    chk("t3_cmd_error_c2", 32'(cmd_error), 32'd0);
    repeat (3) begin
      step();
      chk("t3_no_out_valid", 32'(out_valid), 32'd0);
    end
`endif

    // Zero and over-length commands
    prev_addr = rd_address;
    send(4'd0, 4'd0, 1'b0);
    chk("t4_len0_cmd_error", 32'(cmd_error), 32'd1);
    chk("t4_len0_rd_address", 32'(rd_address), 32'(prev_addr));
    chk("t4_len0_busy", 32'(busy), 32'd0);
    step();
    chk("t4_len0_error_done", 32'(cmd_error), 32'd0);
    chk("t4_len0_no_valid", 32'(out_valid), 32'd0);
    send(4'd0, 4'd11, 1'b0);
    chk("t4_len11_cmd_error", 32'(cmd_error), 32'd1);
    chk("t4_len11_rd_address", 32'(rd_address), 32'(prev_addr));
    chk("t4_len11_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("t4_len11_no_valid", 32'(out_valid), 32'd0);

    // Reset after the second beat of a Len=6 command
    send(4'd0, 4'd6, 1'b1);
    step();
    step();
    step();
    step();
    rst       = 1'b1;
    out_ready = 1'b0;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    chk("t5_out_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
    beat_log.delete();
    send(4'd5, 4'd2, 1'b1);
    wait_idle(100, 1'b0);
    chk("t5_beat_count", 32'(beat_log.size()), 32'd2);

    // Full-depth read at full rate
    beat_log.delete();
    send(4'd0, 4'd10, 1'b1);
    wait_idle(100, 1'b0);
    chk("t6_beat_count", 32'(beat_log.size()), 32'd10);
    for (int i = 0; i < beat_log.size() && i < 10; i++)
      chk("t6_beat_cycle", 32'(beat_log[i] - hs), 32'(3 + i));

    step();
    step();
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
